// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file: FSM encodings and the default
// datapath widths that decode and writeback also build against.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback and the register file.
//
// Handshake: there is no valid/ready pair per transfer. ready is a level
// that is high only once the array is initialised; wt_en and iss_en are
// single-cycle qualifiers that take effect on the rising edge if and only if
// ready is high in that cycle, and are silently dropped otherwise. Reads are
// combinational and need no handshake; they return 0 while ready is low.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = 2
);

  logic                  clr_req;
  logic                  ready;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wt_en;
  logic [ADDR_W-1:0]     wt_addr;
  logic [DATA_W-1:0]     wt_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [ADDR_W:0]       busy_cnt;
  state_t                dbg_state;

  modport master (
    output clr_req, rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr,
    input  ready, rd_data, rd_busy, busy_cnt, dbg_state
  );

  modport slave (
    input  clr_req, rd_addr, wt_en, wt_addr, wt_data, iss_en, iss_addr,
    output ready, rd_data, rd_busy, busy_cnt, dbg_state
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with an incrementally maintained population count.
// A set and a clear of the same register in one cycle leaves it set.
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]        cnt
);

  logic [(2**ADDR_W)-1:0] busy_n;
  logic [ADDR_W:0]        cnt_n;
  logic                   inc;
  logic                   dec;

  // Next busy vector (set applied last so it wins) and the count delta
  always_comb begin
    busy_n = busy;
    inc    = set_en && !busy[set_addr];
    dec    = clr_en && busy[clr_addr] && !(set_en && (set_addr == clr_addr));
    if (clr_en) busy_n[clr_addr] = 1'b0;
    if (set_en) busy_n[set_addr] = 1'b1;
    cnt_n = cnt;
    if (inc && !dec)      cnt_n = cnt + 1'b1;
    else if (dec && !inc) cnt_n = cnt - 1'b1;
  end

  // Busy state register; clr wipes everything in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else if (clr) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_n;
      cnt  <= cnt_n;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with optional write bypass, a busy scoreboard
// and a sequential clear engine that zeroes one entry per cycle after reset
// or clr_req, so the data flops themselves carry no reset.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = '1;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic                run;
  logic                wt_ok;
  logic                iss_ok;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [ADDR_W-1:0]   ra;

  assign run = (state == ST_RUN);

  // Writes and issues only count in RUN; register 0 is hard-wired when enabled
  assign wt_ok  = run && bus.wt_en  && !((ZERO_REG != 0) && (bus.wt_addr  == '0));
  assign iss_ok = run && bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  assign bus.ready     = run;
  assign bus.dbg_state = state;

  // FSM state and clear pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Next state: INIT walks ptr across the array, clr_req restarts the walk
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      ST_INIT: begin
        if (bus.clr_req) begin
          ptr_n = '0;
        end else begin
          ptr_n = ptr + 1'b1;
          if (ptr == LAST_PTR) state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clr_req) begin
          state_n = ST_INIT;
          ptr_n   = '0;
        end
      end
      default: begin
        state_n = ST_INIT;
        ptr_n   = '0;
      end
    endcase
  end

  // Data array: zero fill while initialising, normal writes in RUN
  always_ff @(posedge clk) begin
    if (!run)       mem[ptr]         <= '0;
    else if (wt_ok) mem[bus.wt_addr] <= bus.wt_data;
  end

  // Read muxes with zero-register override and same-cycle write bypass
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (!run)
        bus.rd_data[k*DATA_W +: DATA_W] = '0;
      else if ((ZERO_REG != 0) && (ra == '0))
        bus.rd_data[k*DATA_W +: DATA_W] = '0;
      else if ((BYPASS != 0) && wt_ok && (ra == bus.wt_addr))
        bus.rd_data[k*DATA_W +: DATA_W] = bus.wt_data;
      else
        bus.rd_data[k*DATA_W +: DATA_W] = mem[ra];
      bus.rd_busy[k] = busy[ra];
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr_req),
    .set_en   (iss_ok),
    .set_addr (bus.iss_addr),
    .clr_en   (wt_ok),
    .clr_addr (bus.wt_addr),
    .busy     (busy),
    .cnt      (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 4-port bypassing instance and a 2-port
// non-bypassing instance share one stimulus stream and one reference model.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic        clr_req;
  logic        wt_en;
  logic [4:0]  wt_addr;
  logic [31:0] wt_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [19:0] rd_addr_v;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [32];
  logic        ref_busy [32];
  bit          m_run;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(4)) a_if ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b_if ();

  assign a_if.clr_req  = clr_req;
  assign a_if.wt_en    = wt_en;
  assign a_if.wt_addr  = wt_addr;
  assign a_if.wt_data  = wt_data;
  assign a_if.iss_en   = iss_en;
  assign a_if.iss_addr = iss_addr;
  assign a_if.rd_addr  = rd_addr_v;
  assign b_if.clr_req  = clr_req;
  assign b_if.wt_en    = wt_en;
  assign b_if.wt_addr  = wt_addr;
  assign b_if.wt_data  = wt_data;
  assign b_if.iss_en   = iss_en;
  assign b_if.iss_addr = iss_addr;
  assign b_if.rd_addr  = rd_addr_v[9:0];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // ---------------- model helpers ----------------
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]  = 32'h0;
      ref_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ad, input bit byp);
    if (!m_run || ad == 5'd0) return 32'h0;
    if (byp && wt_en && ad == wt_addr) return wt_data;
    return ref_mem[ad];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] ad);
    if (!m_run) return 32'h0;
    return {31'b0, ref_busy[ad]};
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(ref_busy[i]);
    return n;
  endfunction

  // Observation lanes: 0-3 dut_a data, 4-5 dut_b data, 6-9 dut_a busy, 10-11 dut_b busy
  function automatic logic [31:0] obs(input int k);
    if (k < 4)  return a_if.rd_data[k*32 +: 32];
    if (k < 6)  return b_if.rd_data[(k-4)*32 +: 32];
    if (k < 10) return {31'b0, a_if.rd_busy[k-6]};
    return {31'b0, b_if.rd_busy[k-10]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive read addresses and push the 12 expected lane values
  task automatic drive_reads(input logic [4:0] p0, input logic [4:0] p1,
                             input logic [4:0] p2, input logic [4:0] p3);
    logic [4:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    rd_addr_v = {p3, p2, p1, p0};
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_rd(p[k], 1'b1));
    for (int k = 0; k < 2; k++) exp_q.push_back(exp_rd(p[k], 1'b0));
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_busy(p[k]));
    for (int k = 0; k < 2; k++) exp_q.push_back(exp_busy(p[k]));
  endtask

  // Advance one clock, updating the model with the inputs present at the edge
  task automatic tick();
    if (m_run) begin
      if (clr_req) begin
        model_clear();
        m_run = 1'b0;
      end else begin
        if (wt_en && wt_addr != 5'd0) begin
          ref_mem[wt_addr]  = wt_data;
          ref_busy[wt_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 5'd0) ref_busy[iss_addr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until each DUT raises ready (0 = never seen)
  task automatic wait_ready(output int na, output int nb);
    int n = 0;
    na = 0;
    nb = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (a_if.ready && na == 0) na = n;
      if (b_if.ready && nb == 0) nb = n;
      if (a_if.ready || b_if.ready) begin
        wt_en  = 1'b0;
        iss_en = 1'b0;
      end
    end while ((na == 0 || nb == 0) && n < 200);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int na, nb;
    logic [4:0] ad;
    logic [31:0] e, g;
    checks++; if (a_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_a got=%b exp=0", a_if.ready); end
    checks++; if (b_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready_b got=%b exp=0", b_if.ready); end
    checks++; if (a_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", a_if.busy_cnt); end
    checks++; if (a_if.dbg_state !== ST_INIT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", a_if.dbg_state, ST_INIT); end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(na, nb);
    checks++; if (na != 32) begin errors++; $display("FAIL init_len_a got=%0d exp=32", na); end
    checks++; if (nb != 32) begin errors++; $display("FAIL init_len_b got=%0d exp=32", nb); end
    m_run = 1'b1;
    checks++; if (a_if.dbg_state !== ST_RUN) begin errors++; $display("FAIL run_state got=%0d exp=%0d", a_if.dbg_state, ST_RUN); end
    checks++; if (b_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL init_cnt_b got=%0d exp=0", b_if.busy_cnt); end
    for (int i = 0; i < 32; i++) begin
      ad = 5'(i);
      drive_reads(ad, ~ad, ad ^ 5'd3, 5'd31 - ad);
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
        e = exp_q.pop_front();
        g = obs(k);
        checks++;
        if (g !== e) begin errors++; $display("FAIL init_read lane%0d addr=%h got=%h exp=%h", k, rd_addr_v, g, e); end
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e, g;
    wt_en = 1'b1; wt_addr = 5'd5; wt_data = 32'hDEADBEEF;
    tick();
    wt_en = 1'b0;
    drive_reads(5'd5, 5'd5, 5'd5, 5'd5);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL write_r5 lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
    wt_en = 1'b1; wt_addr = 5'd0; wt_data = 32'h00001234;
    drive_reads(5'd0, 5'd0, 5'd5, 5'd0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL write_r0_same lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
    wt_en = 1'b0;
    drive_reads(5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL write_r0_next lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] e, g;
    wt_en = 1'b1; wt_addr = 5'd7; wt_data = 32'hA5A5A5A5;
    drive_reads(5'd7, 5'd7, 5'd5, 5'd7);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL bypass_same lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
    wt_en = 1'b0;
    drive_reads(5'd7, 5'd7, 5'd7, 5'd7);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL bypass_next lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g;
    for (int i = 1; i <= 8; i++) begin
      wt_en = 1'b1; wt_addr = 5'(i + 10); wt_data = $urandom;
      drive_reads(5'(i + 10), 5'(i + 9), 5'(i + 10), 5'($urandom_range(1, 31)));
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
        e = exp_q.pop_front(); g = obs(k); checks++;
        if (g !== e) begin errors++; $display("FAIL b2b_w%0d lane%0d got=%h exp=%h", i, k, g, e); end
      end
      tick();
    end
    wt_en = 1'b0;
    drive_reads(5'd11, 5'd14, 5'd18, 5'd12);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_final lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_scoreboard();
    logic [31:0] e, g;
    iss_en = 1'b1; iss_addr = 5'd3; tick();
    iss_addr = 5'd9; tick();
    iss_en = 1'b0;
    drive_reads(5'd3, 5'd9, 5'd4, 5'd0);
    @(negedge clk);
    checks++; if (a_if.busy_cnt !== 6'(model_cnt())) begin errors++; $display("FAIL sb_cnt2_a got=%0d exp=%0d", a_if.busy_cnt, model_cnt()); end
    checks++; if (b_if.busy_cnt !== 6'(model_cnt())) begin errors++; $display("FAIL sb_cnt2_b got=%0d exp=%0d", b_if.busy_cnt, model_cnt()); end
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL sb_issue lane%0d got=%h exp=%h", k, g, e); end
    end
    // write and issue r3 together: issue wins, data still lands
    wt_en = 1'b1; wt_addr = 5'd3; wt_data = 32'hCAFE0003;
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    wt_en = 1'b0; iss_en = 1'b0;
    drive_reads(5'd3, 5'd9, 5'd3, 5'd3);
    @(negedge clk);
    checks++; if (a_if.busy_cnt !== 6'(model_cnt())) begin errors++; $display("FAIL sb_wi_cnt got=%0d exp=%0d", a_if.busy_cnt, model_cnt()); end
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL sb_wi lane%0d got=%h exp=%h", k, g, e); end
    end
    // re-issue busy r3, issue r0, write non-busy r4: count must not move
    iss_en = 1'b1; iss_addr = 5'd3; tick();
    iss_addr = 5'd0; tick();
    iss_en = 1'b0;
    wt_en = 1'b1; wt_addr = 5'd4; wt_data = 32'h00000055; tick();
    wt_en = 1'b0;
    checks++; if (a_if.busy_cnt !== 6'd2) begin errors++; $display("FAIL sb_hold_cnt got=%0d exp=2", a_if.busy_cnt); end
    wt_en = 1'b1; wt_addr = 5'd9; wt_data = 32'h00000099; tick();
    wt_en = 1'b0;
    drive_reads(5'd9, 5'd3, 5'd4, 5'd0);
    @(negedge clk);
    checks++; if (a_if.busy_cnt !== 6'd1) begin errors++; $display("FAIL sb_clr_cnt_a got=%0d exp=1", a_if.busy_cnt); end
    checks++; if (b_if.busy_cnt !== 6'(model_cnt())) begin errors++; $display("FAIL sb_clr_cnt_b got=%0d exp=%0d", b_if.busy_cnt, model_cnt()); end
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL sb_clr lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_clear();
    int na, nb;
    logic [31:0] e, g;
    iss_en = 1'b1; iss_addr = 5'd10; tick();
    iss_addr = 5'd11; tick();
    iss_en = 1'b0;
    checks++; if (a_if.busy_cnt !== 6'd3) begin errors++; $display("FAIL clr_pre_cnt got=%0d exp=3", a_if.busy_cnt); end
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    checks++; if (a_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL clr_cnt_a got=%0d exp=0", a_if.busy_cnt); end
    checks++; if (b_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL clr_cnt_b got=%0d exp=0", b_if.busy_cnt); end
    checks++; if (a_if.ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b exp=0", a_if.ready); end
    // traffic during INIT must be ignored and reads return 0
    wt_en = 1'b1; wt_addr = 5'd4; wt_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd4;
    drive_reads(5'd4, 5'd4, 5'd4, 5'd4);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL clr_init_read lane%0d got=%h exp=%h", k, g, e); end
    end
    wait_ready(na, nb);
    checks++; if (na != 32) begin errors++; $display("FAIL clr_len_a got=%0d exp=32", na); end
    checks++; if (nb != 32) begin errors++; $display("FAIL clr_len_b got=%0d exp=32", nb); end
    m_run = 1'b1;
    drive_reads(5'd4, 5'd3, 5'd10, 5'd11);
    @(negedge clk);
    checks++; if (a_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL clr_post_cnt got=%0d exp=0", a_if.busy_cnt); end
    for (int k = 0; k < 12; k++) begin
      e = exp_q.pop_front(); g = obs(k); checks++;
      if (g !== e) begin errors++; $display("FAIL clr_post lane%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_reset_mid_init();
    int na, nb;
    logic [4:0] ad;
    logic [31:0] e, g;
    wt_en = 1'b1; wt_addr = 5'd6; wt_data = 32'h00000077; tick();
    wt_en = 1'b0;
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (a_if.ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", a_if.ready); end
    checks++; if (a_if.dbg_state !== ST_INIT) begin errors++; $display("FAIL mid_rst_state got=%0d exp=%0d", a_if.dbg_state, ST_INIT); end
    checks++; if (b_if.busy_cnt !== 6'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", b_if.busy_cnt); end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(na, nb);
    checks++; if (na != 32) begin errors++; $display("FAIL mid_rst_len_a got=%0d exp=32", na); end
    checks++; if (nb != 32) begin errors++; $display("FAIL mid_rst_len_b got=%0d exp=32", nb); end
    m_run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ad = 5'(i);
      drive_reads(5'd31 - ad, ad, 5'd6, ad ^ 5'd16);
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
        e = exp_q.pop_front(); g = obs(k); checks++;
        if (g !== e) begin errors++; $display("FAIL mid_rst_read lane%0d addr=%h got=%h exp=%h", k, rd_addr_v, g, e); end
      end
    end
  endtask

  // ---------------- main sequence / final report ----------------
  initial begin
    rst = 1'b1; clr_req = 1'b0;
    wt_en = 1'b0; wt_addr = 5'd0; wt_data = 32'h0;
    iss_en = 1'b0; iss_addr = 5'd0; rd_addr_v = '0;
    m_run = 1'b0;
    model_clear();
    #12;
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_scoreboard();
    test_clear();
    test_reset_mid_init();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
